rwire_bypass_fifo: RTL
======================

# rwire_bypass_fifo

Bypass FIFO that consumes the WHAS/WGET pair of an upstream RWire primitive and holds the value until the downstream rule dequeues it. When empty, a value set on the wire is visible at the output in the same cycle (zero-latency bypass). Otherwise it is buffered in order. It sits directly downstream of RWire instances in the ASIC Bluespec Verilog primitive library. Lost-write and underflow conditions are reported as sticky error flags.

## Interface
- width, 1: data width in bits.
- depth, 4: storage entries; a power of two, at least 2.
- cntw, 3: COUNT width; must equal log2(depth)+1.
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- WHAS  input  1  enqueue strobe, driven by upstream RWire WHAS.
- WGET  input  width  enqueue data, driven by upstream RWire WGET.
- FULL_N  output  1  high when an entry can be accepted.
- DEQ  input  1  dequeue strobe from the downstream consumer.
- D_OUT  output  width  head data, or bypassed WGET when empty.
- EMPTY_N  output  1  high when D_OUT is valid.
- CLR  input  1  synchronous flush.
- COUNT  output  cntw  stored entries, excluding a bypassed value.
- ERR_OVF  output  1  sticky; set when WHAS is high while FULL_N is low.
- ERR_UDF  output  1  sticky; set when DEQ is high while EMPTY_N is low.

## Operation
- Storage: a depth-entry register array with read pointer rp, write pointer wp, and count cnt.
  - rp and wp are log2(depth) bits and wrap modulo depth.
  - cnt ranges from 0 to depth.
- State: an implicit two-mode machine derived from cnt.
  - EMPTY (cnt==0).
  - HOLDING (cnt>0).
- EMPTY mode:
  - D_OUT=WGET and EMPTY_N=WHAS (combinational bypass).
  - WHAS&DEQ: value passes through; nothing is stored; cnt stays 0.
  - WHAS&!DEQ: value is written at wp; wp++; cnt becomes 1.
- HOLDING mode:
  - D_OUT=mem[rp] and EMPTY_N=1.
  - DEQ: rp++ and cnt--.
  - WHAS with FULL_N high: write mem[wp]; wp++; cnt++.
  - Simultaneous WHAS&DEQ: cnt is unchanged and both pointers advance.
- Full:
  - FULL_N=(cnt!=depth).
  - Full with DEQ&WHAS in the same cycle: the enqueue is rejected, because FULL_N is a registered-state function with no pipeline passthrough.
  - The rejected WHAS sets ERR_OVF; stored state is unchanged apart from the dequeue.
- Underflow: DEQ with EMPTY_N low is ignored and sets ERR_UDF.
- CLR:
  - Next edge: rp, wp and cnt go to 0; ERR flags are cleared.
  - CLR overrides WHAS/DEQ in the same cycle; concurrent events are dropped and do not set flags.
- Reset (asynchronous, any time, including mid-transfer):
  - rp, wp, cnt go to 0 and ERR_OVF=ERR_UDF=0 immediately.
  - Stored data is not reset.
- Outputs while RST is high:
  - FULL_N=1, COUNT=0, ERR_* = 0.
  - EMPTY_N=WHAS and D_OUT=WGET (bypass path is combinational).

## Timing
- Latency:
  - 0 cycles WHAS to D_OUT when empty.
  - Otherwise the FIFO-order position determines when a value reaches the head.
- FULL_N and COUNT depend only on registered state, so they have no combinational path from any input.
- EMPTY_N and D_OUT have a combinational path from WHAS/WGET only in EMPTY mode.
- DEQ must not combinationally depend on FULL_N.
- Throughput: one enqueue and one dequeue per cycle in steady state.
- Pointer wrap: the pointer going from depth-1 to 0 must be seamless and preserve FIFO order.

## Structure
- Shared package holds:
  - the log2 helper used to derive the pointer width;
  - a parameter-check macro asserting that depth is a power of two, at least 2, and that cntw == log2(depth)+1.
- Natural sub-module: `fifo_regarray`, a width×depth register file with one write port and one async read port.
  - Write enable = WHAS & FULL_N & !(bypass consumed) & !CLR.
- Pointer, count and flag logic stay in the top level.
- No dependence on the BSV_ASSIGNMENT_DELAY define beyond applying it to register updates.

## Test plan
- Bypass:
  - Empty; WHAS=1, WGET=0x5, DEQ=1 in the same cycle → D_OUT=0x5 and EMPTY_N=1 in that cycle.
  - After the edge: COUNT=0, EMPTY_N=0.
- Fill and drain, depth=4:
  - Enqueue 1,2,3,4 on consecutive cycles with no DEQ → COUNT=4, FULL_N=0.
  - Then DEQ ×4 → D_OUT 1,2,3,4 in order, ending EMPTY_N=0.
- Full collision:
  - At COUNT=4 drive WHAS=1 (0x9) and DEQ=1 → head pops; 0x9 is dropped.
  - Result: ERR_OVF=1, COUNT=3.
- Wrap-around: 10 cycles of simultaneous enq/deq with COUNT held at 2 → output sequence matches the input sequence delayed by 2; no errors.
- Underflow then CLR:
  - DEQ when empty → ERR_UDF=1.
  - Next cycle CLR=1 with WHAS=1 → ERR_UDF=0, COUNT=0; the write is discarded.
- Async reset mid-operation:
  - Assert RST between edges at COUNT=3 → COUNT=0, FULL_N=1 and EMPTY_N=WHAS immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rwire_bypass_fifo_pkg.sv
// Shared helpers for the RWire bypass FIFO: pointer-width derivation,
// parameter legality check, mode encoding and the register-update delay hook.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

`define RWBF_PARAM_CHECK(d, cw) \
    always_comb begin : param_check \
        assert (rwire_bypass_fifo_pkg::param_ok(d, cw)); \
    end

package rwire_bypass_fifo_pkg;

    localparam logic MODE_EMPTY   = 1'b0;
    localparam logic MODE_HOLDING = 1'b1;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit param_ok(input int d, input int cw);
        return (d >= 2) && ((d & (d - 1)) == 0) && (cw == log2(d) + 1);
    endfunction

endpackage

// File: rtl/rwire_bypass_fifo_if.sv
// Handshake bundle between an upstream RWire producer / downstream consumer
// and the bypass FIFO.
interface rwire_bypass_fifo_if #(
    parameter int width = 1,
    parameter int cntw  = 3
);
    logic             WHAS;
    logic [width-1:0] WGET;
    logic             FULL_N;
    logic             DEQ;
    logic [width-1:0] D_OUT;
    logic             EMPTY_N;
    logic             CLR;
    logic [cntw-1:0]  COUNT;
    logic             ERR_OVF;
    logic             ERR_UDF;

    modport master (
        output WHAS, WGET, DEQ, CLR,
        input  FULL_N, D_OUT, EMPTY_N, COUNT, ERR_OVF, ERR_UDF
    );

    modport slave (
        input  WHAS, WGET, DEQ, CLR,
        output FULL_N, D_OUT, EMPTY_N, COUNT, ERR_OVF, ERR_UDF
    );
endinterface

// File: rtl/rwire_bypass_fifo_regarray.sv
// width x depth register file: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module fifo_regarray #(
    parameter int width = 1,
    parameter int depth = 4,
    parameter int aw    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);
    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= `BSV_ASSIGNMENT_DELAY wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rwire_bypass_fifo.sv
// Bypass FIFO behind an RWire: an empty FIFO forwards WHAS/WGET straight to
// the output; otherwise entries are buffered in order. Sticky overflow/underflow flags.
module rwire_bypass_fifo
    import rwire_bypass_fifo_pkg::*;
#(
    parameter int width = 1,
    parameter int depth = 4,
    parameter int cntw  = 3
) (
    input logic                CLK,
    input logic                RST,
    rwire_bypass_fifo_if.slave io
);
    // mode         | meaning
    // MODE_EMPTY   | cnt==0, output is the live wire value (bypass)
    // MODE_HOLDING | cnt>0, output is the stored head entry
    localparam int pw = log2(depth);

    `RWBF_PARAM_CHECK(depth, cntw)

    logic [pw-1:0]    rp;
    logic [pw-1:0]    wp;
    logic [cntw-1:0]  cnt;
    logic             err_ovf;
    logic             err_udf;
    logic [width-1:0] head;
    logic             mode;
    logic             full_n;
    logic             empty_n;
    logic             bypass;
    logic             enq;
    logic             pop;

    assign mode    = (cnt == '0) ? MODE_EMPTY : MODE_HOLDING;
    assign full_n  = (cnt != cntw'(depth));
    assign empty_n = (mode == MODE_EMPTY) ? io.WHAS : 1'b1;
    assign bypass  = (mode == MODE_EMPTY) & io.WHAS & io.DEQ;

    // full_n comes from registered state only, so a full FIFO rejects a
    // same-cycle enqueue even while the head is being popped.
    assign enq = io.WHAS & full_n & ~bypass & ~io.CLR;
    assign pop = io.DEQ & (mode == MODE_HOLDING) & ~io.CLR;

    fifo_regarray #(
        .width (width),
        .depth (depth),
        .aw    (pw)
    ) u_regarray (
        .clk   (CLK),
        .we    (enq),
        .waddr (wp),
        .wdata (io.WGET),
        .raddr (rp),
        .rdata (head)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rp      <= '0;
            wp      <= '0;
            cnt     <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (io.CLR) begin
            rp      <= `BSV_ASSIGNMENT_DELAY '0;
            wp      <= `BSV_ASSIGNMENT_DELAY '0;
            cnt     <= `BSV_ASSIGNMENT_DELAY '0;
            err_ovf <= `BSV_ASSIGNMENT_DELAY 1'b0;
            err_udf <= `BSV_ASSIGNMENT_DELAY 1'b0;
        end else begin
            rp  <= `BSV_ASSIGNMENT_DELAY rp + pw'(pop);
            wp  <= `BSV_ASSIGNMENT_DELAY wp + pw'(enq);
            cnt <= `BSV_ASSIGNMENT_DELAY cnt + cntw'(enq) - cntw'(pop);
            if (io.WHAS & ~full_n) err_ovf <= `BSV_ASSIGNMENT_DELAY 1'b1;
            if (io.DEQ & ~empty_n) err_udf <= `BSV_ASSIGNMENT_DELAY 1'b1;
        end
    end

    assign io.FULL_N  = full_n;
    assign io.EMPTY_N = empty_n;
    assign io.D_OUT   = (mode == MODE_EMPTY) ? io.WGET : head;
    assign io.COUNT   = cnt;
    assign io.ERR_OVF = err_ovf;
    assign io.ERR_UDF = err_udf;
endmodule
